// File: rtl/obstacle_scheduler_if.sv
// Signal bundle between the game-state logic, the obstacle scheduler and the
// per-lane obstacle renderers.
interface obstacle_scheduler_if;
  logic        i_v_sync;
  logic        i_is_finished;
  logic        i_is_dead;
  logic [2:0]  i_crushed;
  logic [2:0]  o_active;
  logic [15:0] o_depth_l;
  logic [15:0] o_depth_c;
  logic [15:0] o_depth_r;
  logic [2:0]  o_spawn;
  logic        o_frame_tick;
  logic [15:0] o_passed_count;
  logic [15:0] o_crushed_count;

  modport master (
    output i_v_sync, i_is_finished, i_is_dead, i_crushed,
    input  o_active, o_depth_l, o_depth_c, o_depth_r, o_spawn, o_frame_tick,
           o_passed_count, o_crushed_count
  );

  modport slave (
    input  i_v_sync, i_is_finished, i_is_dead, i_crushed,
    output o_active, o_depth_l, o_depth_c, o_depth_r, o_spawn, o_frame_tick,
           o_passed_count, o_crushed_count
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Frame-synchronous launcher/advancer for the three obstacle lanes: picks spawn
// lanes from an LFSR, steps depths once per frame and tallies passes/crushes.
module obstacle_scheduler #(
  parameter int unsigned DEPTH_END  = 592,
  parameter int unsigned SPAWN_GAP  = 120,
  parameter int unsigned MIN_GAP    = 40,
  parameter int unsigned MAX_ACTIVE = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  obstacle_scheduler_if.slave bus
);

  localparam int unsigned      NUM_LANES = 3;
  localparam int unsigned      CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [15:0]      LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {IDLE, RUN} lane_state_e;

  logic [1:0]           rst_pipe;
  logic                 rst_n;
  logic [2:0]           vs_q;
  logic                 tick_q;
  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [CNT_W-1:0]     depth_q [NUM_LANES];
  logic [CNT_W-1:0]     depth_d [NUM_LANES];
  logic [CNT_W-1:0]     gap_q, gap_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     passed_q, passed_d;
  logic [CNT_W-1:0]     crushed_q, crushed_d;
  logic [NUM_LANES-1:0] spawn_q, spawn_d;
  logic [NUM_LANES-1:0] grant;
  logic [1:0]           live_cnt;
  logic [1:0]           cand;
  logic [1:0]           lane_idx;
  logic                 picked;
  logic                 eligible;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    passed_d  = passed_q;
    crushed_d = crushed_q;
    spawn_d   = '0;
    grant     = '0;
    live_cnt  = '0;
    picked    = 1'b0;
    lane_idx  = '0;

    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (state_q[i] == RUN) live_cnt = live_cnt + 2'd1;
    end

    // Candidate lane 3 folds onto centre; busy candidates rotate L->C->R->L
    cand = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lane_idx = 2'((32'(cand) + k) % NUM_LANES);
      if (!picked && state_q[lane_idx] == IDLE) begin
        grant[lane_idx] = 1'b1;
        picked          = 1'b1;
      end
    end

    eligible = (gap_q >= CNT_W'(MIN_GAP)) &&
               ((gap_q >= CNT_W'(SPAWN_GAP)) || (lfsr_q[7:4] == 4'd0)) &&
               (32'(live_cnt) < MAX_ACTIVE) && picked;

    if (tick_q && !(bus.i_is_finished || bus.i_is_dead)) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (state_q[i] == RUN) begin
          if (bus.i_crushed[i]) begin
            state_d[i] = IDLE;
            depth_d[i] = '0;
            if (crushed_d != CNT_MAX) crushed_d = crushed_d + CNT_W'(1);
          end else if (depth_q[i] == CNT_W'(DEPTH_END)) begin
            state_d[i] = IDLE;
            depth_d[i] = '0;
            if (passed_d != CNT_MAX) passed_d = passed_d + CNT_W'(1);
          end else begin
            depth_d[i] = depth_q[i] + CNT_W'(1);
          end
        end else if (eligible && grant[i]) begin
          state_d[i] = RUN;
          depth_d[i] = '0;
          spawn_d[i] = 1'b1;
        end
      end
      if (eligible)              gap_d = '0;
      else if (gap_q != CNT_MAX) gap_d = gap_q + CNT_W'(1);
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= '0;
      tick_q    <= 1'b0;
      gap_q     <= '0;
      lfsr_q    <= LFSR_INIT;
      passed_q  <= '0;
      crushed_q <= '0;
      spawn_q   <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= IDLE;
        depth_q[i] <= '0;
      end
    end else begin
      vs_q      <= {vs_q[1:0], bus.i_v_sync};
      tick_q    <= vs_q[1] & ~vs_q[2];
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      passed_q  <= passed_d;
      crushed_q <= crushed_d;
      spawn_q   <= spawn_d;
      state_q   <= state_d;
      depth_q   <= depth_d;
    end
  end

  assign bus.o_active[0]     = (state_q[0] == RUN);
  assign bus.o_active[1]     = (state_q[1] == RUN);
  assign bus.o_active[2]     = (state_q[2] == RUN);
  assign bus.o_depth_l       = depth_q[0];
  assign bus.o_depth_c       = depth_q[1];
  assign bus.o_depth_r       = depth_q[2];
  assign bus.o_spawn         = spawn_q;
  assign bus.o_frame_tick    = tick_q;
  assign bus.o_passed_count  = passed_q;
  assign bus.o_crushed_count = crushed_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomised bench for obstacle_scheduler against a per-frame behavioural model
// of lanes, spawn gap, LFSR and counters.
module tb_obstacle_scheduler;

  localparam int DEPTH_END  = 592;
  localparam int SPAWN_GAP  = 120;
  localparam int MIN_GAP    = 40;
  localparam int MAX_ACTIVE = 2;

  logic clk = 1'b0;
  logic rst_n;

  obstacle_scheduler_if bus ();

  obstacle_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_live [3];
  int          m_depth [3];
  int          m_gap, m_pass, m_crush;
  int unsigned m_lfsr;
  logic [2:0]  m_spawn;
  int          tick_no;
  int          first_lane;

  function automatic void model_reset();
    for (int l = 0; l < 3; l++) begin m_live[l] = 0; m_depth[l] = 0; end
    m_gap = 0; m_lfsr = 'hACE1; m_pass = 0; m_crush = 0; m_spawn = '0;
  endfunction

  // One frame of game rules, decided on the state before the frame
  function automatic void model_step(logic [2:0] cr, logic [1:0] frz);
    int busy = 0;
    int grant = -1;
    int cand;
    m_spawn = '0;
    if (frz != 2'b00) return;
    foreach (m_live[l]) busy += m_live[l];
    if (m_gap >= MIN_GAP && (m_gap >= SPAWN_GAP || ((m_lfsr >> 4) % 16) == 0) &&
        busy < MAX_ACTIVE && busy < 3) begin
      cand = int'(m_lfsr % 4);
      if (cand == 3) cand = 1;
      for (int k = 0; k < 3; k++)
        if (grant < 0 && m_live[(cand + k) % 3] == 0) grant = (cand + k) % 3;
    end
    for (int l = 0; l < 3; l++) begin
      if (m_live[l] != 0) begin
        if (cr[l]) begin
          m_live[l] = 0; m_depth[l] = 0;
          if (m_crush < 65535) m_crush++;
        end else if (m_depth[l] == DEPTH_END) begin
          m_live[l] = 0; m_depth[l] = 0;
          if (m_pass < 65535) m_pass++;
        end else begin
          m_depth[l]++;
        end
      end else if (l == grant) begin
        m_live[l] = 1; m_depth[l] = 0;
      end
    end
    m_gap  = (grant >= 0) ? 0 : ((m_gap < 65535) ? m_gap + 1 : 65535);
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    if (grant >= 0) m_spawn[grant] = 1'b1;
  endfunction

  function automatic logic [85:0] model_vec();
    return {m_live[2] != 0, m_live[1] != 0, m_live[0] != 0,
            16'(m_depth[0]), 16'(m_depth[1]), 16'(m_depth[2]),
            m_spawn, 16'(m_pass), 16'(m_crush)};
  endfunction

  function automatic logic [85:0] dut_vec();
    return {bus.o_active, bus.o_depth_l, bus.o_depth_c, bus.o_depth_r,
            bus.o_spawn, bus.o_passed_count, bus.o_crushed_count};
  endfunction

  function automatic logic [15:0] dut_depth(int l);
    case (l)
      0:       return bus.o_depth_l;
      1:       return bus.o_depth_c;
      default: return bus.o_depth_r;
    endcase
  endfunction

  // Drives one v_sync pulse; returns one cycle after the tick, outputs updated
  task automatic frame(input logic [2:0] cr, input logic [1:0] frz);
    bit seen;
    seen = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.i_crushed     = cr;
    bus.i_is_finished = frz[1];
    bus.i_is_dead     = frz[0];
    bus.i_v_sync      = 1'b1;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #1;
      seen = bus.o_frame_tick;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL frame_tick_timeout: got no tick, want tick within 6 cycles");
    end
    model_step(cr, frz);
    @(posedge clk); #1;
    bus.i_v_sync = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    bit seen;
    edges = 0; seen = 0;
    rst_n = 1'b0;
    bus.i_v_sync = 1'b0; bus.i_is_finished = 1'b0; bus.i_is_dead = 1'b0; bus.i_crushed = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 86'd0 || bus.o_frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %h tick %b, want 0 tick 0", dut_vec(), bus.o_frame_tick);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.i_v_sync = 1'b1;
    while (!seen && edges < 8) begin
      @(posedge clk); #1;
      edges++;
      seen = bus.o_frame_tick;
    end
    n_cmp++;
    if (!seen || edges != 3) begin
      n_err++;
      $display("FAIL tick_latency: got %0d edges (seen %0b), want 3", edges, seen);
    end
    model_step(3'b000, 2'b00);
    tick_no = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL first_tick_state: got %h want %h", dut_vec(), model_vec());
    end
    n_cmp++;
    if (bus.o_frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL tick_width: got %b want 0", bus.o_frame_tick);
    end
    bus.i_v_sync = 1'b0;
  endtask

  task automatic test_first_spawn();
    bit found;
    found = 0;
    while (!found && tick_no < 130) begin
      frame(3'b000, 2'b00);
      tick_no++;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL spawn_search tick %0d: got %h want %h", tick_no, dut_vec(), model_vec());
      end
      if (bus.o_spawn != 3'b000) found = 1;
    end
    n_cmp++;
    if (!found || tick_no < MIN_GAP + 1 || tick_no > SPAWN_GAP + 1) begin
      n_err++;
      $display("FAIL first_spawn_tick: got %0d (found %0b), want 41..121", tick_no, found);
    end
    n_cmp++;
    if (!$onehot(bus.o_spawn)) begin
      n_err++;
      $display("FAIL spawn_onehot: got %b want one-hot", bus.o_spawn);
    end
    first_lane = bus.o_spawn[0] ? 0 : (bus.o_spawn[1] ? 1 : 2);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.o_spawn !== 3'b000) begin
      n_err++;
      $display("FAIL spawn_width: got %b want 000", bus.o_spawn);
    end
  endtask

  task automatic test_lifecycle();
    for (int k = 1; k <= DEPTH_END; k++) begin
      frame(3'b000, 2'b00);
      n_cmp++;
      if (dut_vec() !== model_vec() || dut_depth(first_lane) !== 16'(k)) begin
        n_err++;
        $display("FAIL life_depth step %0d: got %h depth %0d want %h depth %0d",
                 k, dut_vec(), dut_depth(first_lane), model_vec(), k);
      end
    end
    frame(3'b000, 2'b00);
    n_cmp++;
    if (bus.o_active[first_lane] !== 1'b0 || dut_depth(first_lane) !== 16'd0 ||
        bus.o_passed_count !== 16'd1 || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL life_retire: got active %b depth %0d passed %0d, want lane %0d idle depth 0 passed 1",
               bus.o_active, dut_depth(first_lane), bus.o_passed_count, first_lane);
    end
  endtask

  task automatic test_crush();
    int lane, idle, n, c0;
    logic [2:0] cr;
    lane = -1; idle = -1; n = 0;
    while (lane < 0 && n < 800) begin
      for (int l = 0; l < 3; l++) if (m_live[l] != 0 && m_depth[l] == 300) lane = l;
      if (lane < 0) begin
        frame(3'b000, 2'b00);
        n++;
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_err++;
          $display("FAIL crush_approach: got %h want %h", dut_vec(), model_vec());
        end
      end
    end
    n_cmp++;
    if (lane < 0) begin
      n_err++;
      $display("FAIL crush_setup: got no lane at depth 300, want one within 800 frames");
      return;
    end
    c0 = m_crush;
    cr = '0; cr[lane] = 1'b1;
    frame(cr, 2'b00);
    n_cmp++;
    if (bus.o_active[lane] !== 1'b0 || bus.o_crushed_count !== 16'(c0 + 1) ||
        bus.o_passed_count !== 16'(m_pass) || dut_depth(lane) !== 16'd0) begin
      n_err++;
      $display("FAIL crush_live: got active %b crushed %0d passed %0d, want lane %0d idle crushed %0d passed %0d",
               bus.o_active, bus.o_crushed_count, bus.o_passed_count, lane, c0 + 1, m_pass);
    end
    for (int l = 0; l < 3; l++) if (idle < 0 && m_live[l] == 0) idle = l;
    c0 = m_crush;
    cr = '0; cr[idle] = 1'b1;
    frame(cr, 2'b00);
    n_cmp++;
    if (bus.o_crushed_count !== 16'(c0) || dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL crush_idle: got crushed %0d vec %h want crushed %0d vec %h",
               bus.o_crushed_count, dut_vec(), c0, model_vec());
    end
  endtask

  task automatic test_freeze();
    logic [85:0] held;
    frame(3'b000, 2'b00);
    held = model_vec();
    held[34:32] = 3'b000;
    for (int f = 0; f < 55; f++) begin
      frame(3'($urandom_range(0, 7)), (f < 50) ? 2'b01 : 2'b10);
      n_cmp++;
      if (dut_vec() !== held) begin
        n_err++;
        $display("FAIL freeze_hold frame %0d: got %h want %h", f, dut_vec(), held);
      end
    end
    for (int f = 0; f < 150; f++) begin
      frame(3'b000, 2'b00);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL freeze_resume frame %0d: got %h want %h", f, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_occupancy();
    logic [2:0] cr;
    logic [1:0] frz;
    for (int f = 0; f < 2000; f++) begin
      for (int l = 0; l < 3; l++) cr[l] = ($urandom_range(0, 199) == 0);
      frz = {($urandom_range(0, 49) == 0), 1'b0};
      frame(cr, frz);
      n_cmp++;
      if (dut_vec() !== model_vec() || $countones(bus.o_active) > MAX_ACTIVE) begin
        n_err++;
        $display("FAIL occupancy frame %0d: got %h want %h", f, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int n, ticks;
    bit hit;
    n = 0; ticks = 0; hit = 0;
    while (!hit && n < 900) begin
      frame(3'b000, 2'b00);
      n++;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL areset_approach: got %h want %h", dut_vec(), model_vec());
      end
      for (int l = 0; l < 3; l++) if (m_live[l] != 0 && m_depth[l] == 250) hit = 1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL areset_setup: got no lane at depth 250, want one within 900 frames");
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 86'd0 || bus.o_frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: got %h tick %b want 0", dut_vec(), bus.o_frame_tick);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.o_frame_tick) ticks++;
    end
    n_cmp++;
    if (ticks != 0) begin
      n_err++;
      $display("FAIL areset_no_tick: got %0d ticks want 0", ticks);
    end
    frame(3'b000, 2'b00);
    n_cmp++;
    if (dut_vec() !== model_vec() || bus.o_active !== 3'b000) begin
      n_err++;
      $display("FAIL areset_restart: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_lifecycle();
    test_crush();
    test_freeze();
    test_occupancy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got simulation still running at 3ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
